// File: rtl/scan_display_ctrl.sv
// Refresh scheduler for a 4-digit multiplexed seven-segment display.
// Adds anode-off blanking at every digit change, 16-level PWM brightness and leading-zero blanking.
module scan_display_ctrl #(
    parameter int unsigned CLK_DIV     = 3125,
    parameter int unsigned BLANK_TICKS = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic        blank_lz,
    input  logic [3:0]  brightness,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned PRE_W         = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam logic [3:0] BLANK_PH       = 4'(BLANK_TICKS);
    localparam logic [3:0] AN_OFF         = 4'hF;
    localparam logic [6:0] SEG_OFF        = 7'h7F;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } state_t;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_nxt;
    logic [3:0]       ph_q;
    logic [3:0]       ph_nxt;
    logic [1:0]       idx_q;
    logic [1:0]       idx_nxt;
    logic             tick;
    logic             slot_start;

    logic [3:0]       nib_live;
    logic             upper_zero;
    logic             blank_live;
    logic [3:0]       nib_q;
    logic             blank_q;
    logic [3:0]       bright_q;

    state_t           state_q;
    state_t           state_nxt;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    // Active-low a..g pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        p = SEG_OFF;
        case (n)
            4'h0: p = 7'b0000001;
            4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;
            4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;
            4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;
            4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;
            4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;
            4'hF: p = 7'b0111000;
            default: p = SEG_OFF;
        endcase
        return p;
    endfunction

    // Scan timebase: prescaler -> 16-tick slot phase -> digit index.
    always_comb begin
        tick       = (pre_q == PRE_MAX);
        slot_start = enable && (pre_q == '0) && (ph_q == 4'd0);
        pre_nxt    = pre_q;
        ph_nxt     = ph_q;
        idx_nxt    = idx_q;
        if (!enable) begin
            pre_nxt = '0;
            ph_nxt  = 4'd0;
            idx_nxt = 2'd0;
        end else if (tick) begin
            pre_nxt = '0;
            ph_nxt  = ph_q + 4'd1;
            if (ph_q == 4'hF) begin
                idx_nxt = idx_q + 2'd1;
            end
        end else begin
            pre_nxt = pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            ph_q  <= 4'd0;
            idx_q <= 2'd0;
        end else begin
            pre_q <= pre_nxt;
            ph_q  <= ph_nxt;
            idx_q <= idx_nxt;
        end
    end

    // Digit i>0 is a leading zero when nibbles i..3 are all zero.
    always_comb begin
        nib_live   = 4'(digits >> {idx_q, 2'b00});
        upper_zero = 1'b0;
        case (idx_q)
            2'd1:    upper_zero = (digits[15:4]  == 12'h000);
            2'd2:    upper_zero = (digits[15:8]  == 8'h00);
            2'd3:    upper_zero = (digits[15:12] == 4'h0);
            default: upper_zero = 1'b0;
        endcase
        blank_live = blank_lz && upper_zero;
    end

    // Slot registers freeze the inputs for the whole slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            nib_q    <= 4'd0;
            blank_q  <= 1'b0;
            bright_q <= 4'd0;
        end else if (slot_start) begin
            nib_q    <= nib_live;
            blank_q  <= blank_live;
            bright_q <= brightness;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_BLANK;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Slot phase moves with ph; brightness beyond 16-BLANK_TICKS saturates naturally.
    always_comb begin
        state_nxt = S_OFF;
        if (ph_nxt < BLANK_PH) begin
            state_nxt = S_BLANK;
        end else if (!blank_q && ((ph_nxt - BLANK_PH) < bright_q)) begin
            state_nxt = S_ON;
        end
    end

    // seg only reloads in BLANK, where every anode is off.
    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = seg;
        case (state_q)
            S_BLANK: seg_nxt = decode(slot_start ? nib_live : nib_q);
            S_ON:    an_nxt  = ~(4'b0001 << idx_q);
            default: an_nxt  = AN_OFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_tick <= tick && (ph_q == 4'hF) && (idx_q == 2'd3);
        end
    end

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Bench for scan_display_ctrl: time-based reference model compared every cycle, plus directed pins.
module tb_scan_display_ctrl;

    localparam int CD = 4;
    localparam int BT = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digits = 16'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    scan_display_ctrl #(.CLK_DIV(CD), .BLANK_TICKS(BT)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .digits(digits),
        .blank_lz(blank_lz), .brightness(brightness), .seg(seg), .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[n];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m = clocks since scanning (re)started; outputs lag the scan position by one clock.
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_ft  = 1'b0;
    int         m = 0;
    logic [3:0] l_nib = 4'h0;
    logic [3:0] l_bright = 4'h0;
    logic       l_blank = 1'b0;

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n || !enable) begin
            m = 0; exp_an = 4'hF; exp_seg = 7'h7F; exp_ft = 1'b0;
        end else begin
            int p, d;
            p = (m / CD) % 16;
            d = (m / (16 * CD)) % 4;
            if (m % (16 * CD) == 0) begin
                l_nib    = 4'(digits >> (4 * d));
                l_bright = brightness;
                l_blank  = blank_lz && (d != 0) && ((digits >> (4 * d)) == 16'h0);
            end
            if (p < BT) begin
                exp_an  = 4'hF;
                exp_seg = seg_of(l_nib);
            end else if (!l_blank && (p - BT) < int'(l_bright)) begin
                exp_an = ~(4'b0001 << d);
            end else begin
                exp_an = 4'hF;
            end
            exp_ft = (m % (64 * CD) == 64 * CD - 1);
            m++;
        end
    end

    // Per-cycle comparison against the model, plus the no-glitch rule.
    initial begin
        logic [6:0] prev_seg;
        prev_seg = 7'h7F;
        forever begin
            @(negedge clock);
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("frame_tick", 32'(frame_tick), 32'(exp_ft));
            if (seg !== prev_seg) check("seg_changed_while_lit", 32'(an), 32'hF);
            prev_seg = seg;
        end
    end

    int         cnt [4];
    int         ftc;
    logic [6:0] lit_seg [4];

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic window();
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; lit_seg[i] = 7'h7F; end
        ftc = 0;
        repeat (256) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin cnt[i]++; lit_seg[i] = seg; end
            if (frame_tick) ftc++;
        end
    endtask

    task automatic wait_ft();
        int k;
        k = 0;
        while (frame_tick !== 1'b1 && k < 300) begin @(negedge clock); k++; end
        check("frame_tick_seen", 32'(frame_tick), 32'h1);
    endtask

    task automatic wait_lit();
        int k;
        k = 0;
        while (an === 4'hF && k < 300) begin @(negedge clock); k++; end
        check("anode_lit_seen", 32'(an != 4'hF), 32'h1);
    endtask

    initial begin
        int k;
        // Reset held for five clocks
        step(5);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        digits = 16'h1234; brightness = 4'd15; enable = 1'b1; blank_lz = 1'b0;
        reset_n = 1'b1;

        // Full brightness: 14 ticks lit per slot
        step(256);
        window();
        for (int i = 0; i < 4; i++) check($sformatf("on_time_b15_d%0d", i), 32'(cnt[i]), 32'd56);
        check("seg_digit0_4", 32'(lit_seg[0]), 32'(7'b1001100));
        check("seg_digit2_2", 32'(lit_seg[2]), 32'(7'b0010010));
        check("frames_per_256", 32'(ftc), 32'd1);

        // Async reset while an anode is lit
        wait_lit();
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'hF);
        check("async_reset_seg", 32'(seg), 32'h7F);
        check("async_reset_ft", 32'(frame_tick), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Brightness 4: 16 clocks lit, starting 8 clocks into the slot (+1 registered)
        brightness = 4'd4;
        step(128);
        window();
        for (int i = 0; i < 4; i++) check($sformatf("on_time_b4_d%0d", i), 32'(cnt[i]), 32'd16);
        wait_ft();
        k = 0;
        while (an[0] !== 1'b0 && k < 40) begin @(negedge clock); k++; end
        check("b4_onset", 32'(k), 32'd9);

        // Brightness 0: dark but frames continue
        brightness = 4'd0;
        step(128);
        window();
        for (int i = 0; i < 4; i++) check($sformatf("on_time_b0_d%0d", i), 32'(cnt[i]), 32'd0);
        check("frames_dark", 32'(ftc), 32'd1);

        // Leading-zero blanking
        digits = 16'h0070; blank_lz = 1'b1; brightness = 4'd15;
        step(128);
        window();
        check("lz_d3", 32'(cnt[3]), 32'd0);
        check("lz_d2", 32'(cnt[2]), 32'd0);
        check("lz_d1", 32'(cnt[1]), 32'd56);
        check("lz_d0", 32'(cnt[0]), 32'd56);
        check("lz_seg_d1", 32'(lit_seg[1]), 32'(7'b0001111));
        check("lz_seg_d0", 32'(lit_seg[0]), 32'(7'b0000001));
        blank_lz = 1'b0;
        step(128);
        window();
        for (int i = 0; i < 4; i++) check($sformatf("nolz_d%0d", i), 32'(cnt[i]), 32'd56);
        check("nolz_seg_d3", 32'(lit_seg[3]), 32'(7'b0000001));

        // Mid-slot change leaves the current slot alone
        wait_ft();
        step(20);
        digits = 16'h5555; brightness = 4'd1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (an[0] == 1'b0 && seg == 7'b0000001) k++;
        end
        check("midslot_unchanged", 32'(k), 32'd40);

        // Enable drop for 10 clocks mid-slot
        wait_lit();
        enable = 1'b0;
        @(negedge clock);
        check("disable_an", 32'(an), 32'hF);
        check("disable_seg", 32'(seg), 32'h7F);
        step(9);
        enable = 1'b1;
        k = 0;
        while (an === 4'hF && k < 20) begin @(negedge clock); k++; end
        check("reenable_onset", 32'(k), 32'd9);
        check("reenable_digit0", 32'(an), 32'hE);

        // Randomised inputs against the model
        for (int r = 0; r < 40; r++) begin
            int unsigned sh;
            digits = 16'($urandom);
            if ($urandom_range(2, 0) == 0) begin
                sh = $urandom_range(3, 1);
                digits = digits & 16'(16'hFFFF >> (4 * sh));
            end
            brightness = 4'($urandom);
            blank_lz   = 1'($urandom);
            if ($urandom_range(4, 0) == 0) begin
                enable = 1'b0;
                step(int'($urandom_range(12, 1)));
                enable = 1'b1;
            end
            step(int'($urandom_range(150, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
